// File: rtl/fc_result_reader.sv
// Streams a captured W*OUT_SIZE vector one element per transfer, with optional argmax (FC_READER_ARGMAX_EN).
// First element one cycle after the in_done rise; out_valid/out_ready handshake holds the offered element while stalled.
module fc_result_reader #(
    parameter int OUT_SIZE = 8,
    parameter int W        = 8,
    parameter int IDX_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_done,
    input  logic [W*OUT_SIZE-1:0] in_vector_flat,
    output logic [W-1:0]          out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [IDX_W-1:0]      class_idx,
    output logic [W-1:0]          class_max,
    output logic                  class_valid,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

    state_t                       state_q, state_d;
    logic                         done_q, done_d;
    logic [OUT_SIZE-1:0][W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]             cnt_q, cnt_d;
    logic                         rise;
    logic                         xfer;
    logic                         at_last;
    logic signed [W-1:0]          cur_elem;

    assign rise     = in_done & ~done_q;
    assign xfer     = (state_q == STREAM) & out_ready;
    assign at_last  = (cnt_q == LAST_IDX);
    assign cur_elem = buf_q[cnt_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = STREAM;
            STREAM:  if (xfer && at_last) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == STREAM);
        out_data  = out_valid ? cur_elem : '0;
        out_idx   = out_valid ? cnt_q : '0;
        out_last  = out_valid & at_last;
        busy      = (state_q != IDLE);
        // Any rise outside IDLE is lost, including one on the FINISH-to-IDLE edge.
        overrun   = rise & (state_q != IDLE);
    end

    always_comb begin
        done_d = in_done;
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        if ((state_q == IDLE) && rise) begin
            buf_d = in_vector_flat;
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
            buf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            done_q <= done_d;
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef FC_READER_ARGMAX_EN
    logic signed [W-1:0] run_max_q, run_max_d, cand_max;
    logic [IDX_W-1:0]    run_idx_q, run_idx_d, cand_idx;
    logic signed [W-1:0] class_max_q, class_max_d;
    logic [IDX_W-1:0]    class_idx_q, class_idx_d;

    // Running max tracks transfers, so a stall never double-counts an element.
    always_comb begin
        cand_max = run_max_q;
        cand_idx = run_idx_q;
        if ((cnt_q == '0) || (cur_elem > run_max_q)) begin
            cand_max = cur_elem;
            cand_idx = cnt_q;
        end
        run_max_d   = run_max_q;
        run_idx_d   = run_idx_q;
        class_max_d = class_max_q;
        class_idx_d = class_idx_q;
        if (xfer) begin
            run_max_d = cand_max;
            run_idx_d = cand_idx;
            if (at_last) begin
                class_max_d = cand_max;
                class_idx_d = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max_q   <= '0;
            run_idx_q   <= '0;
            class_max_q <= '0;
            class_idx_q <= '0;
        end else begin
            run_max_q   <= run_max_d;
            run_idx_q   <= run_idx_d;
            class_max_q <= class_max_d;
            class_idx_q <= class_idx_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_max   = class_max_q;
    assign class_valid = (state_q == FINISH);
`else
    assign class_idx   = '0;
    assign class_max   = '0;
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_result_reader.sv
// Directed bench for fc_result_reader: streaming, stalls, overrun, signed argmax, mid-stream reset.
module tb_fc_result_reader;

`ifdef FC_READER_ARGMAX_EN
    localparam bit ARGMAX_EN = 1'b1;
`else
    localparam bit ARGMAX_EN = 1'b0;
`endif

    // Element 0 is the least significant byte.
    localparam logic [63:0] VEC_A = {8'd2, 8'd1, 8'd127, 8'd5, 8'd127, 8'd0, 8'd7, 8'd3};
    localparam logic [63:0] VEC_N = {8'hFF, 8'hF9, 8'hFD, 8'h80, 8'hFE, 8'hF7, 8'hFE, 8'hFB};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_done;
    logic [63:0] in_vector_flat;
    logic [7:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  class_idx;
    logic [7:0]  class_max;
    logic        class_valid;
    logic        busy;
    logic        overrun;

    int nvec = 0;
    int nerr = 0;

    fc_result_reader #(.OUT_SIZE(8), .W(8), .IDX_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_done        (in_done),
        .in_vector_flat (in_vector_flat),
        .out_data       (out_data),
        .out_idx        (out_idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .class_idx      (class_idx),
        .class_max      (class_max),
        .class_valid    (class_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_idx"}, 32'(out_idx), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_cvalid"}, 32'(class_valid), 0);
        chk({tag, "_cidx"}, 32'(class_idx), 0);
        chk({tag, "_cmax"}, 32'(class_max), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    // Checks the offered element for idx from..upto with out_ready high, one transfer per cycle.
    task automatic stream(input string tag, input logic [63:0] v, input int from, input int upto);
        for (int i = from; i <= upto; i++) begin
            chk({tag, "_valid"}, 32'(out_valid), 1);
            chk({tag, "_data"}, 32'(out_data), 32'(v[i*8 +: 8]));
            chk({tag, "_idx"}, 32'(out_idx), 32'(i));
            chk({tag, "_last"}, 32'(out_last), (i == 7) ? 1 : 0);
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_cvalid"}, 32'(class_valid), 0);
            tick();
        end
    endtask

    task automatic chk_finish(input string tag, input int exp_idx, input int exp_max);
        chk({tag, "_fin_valid"}, 32'(out_valid), 0);
        chk({tag, "_fin_busy"}, 32'(busy), 1);
        chk({tag, "_fin_cvalid"}, 32'(class_valid), ARGMAX_EN ? 1 : 0);
        chk({tag, "_fin_cidx"}, 32'(class_idx), ARGMAX_EN ? exp_idx : 0);
        chk({tag, "_fin_cmax"}, 32'(class_max), ARGMAX_EN ? exp_max : 0);
    endtask

    initial begin
        reset          = 1'b1;
        in_done        = 1'b0;
        out_ready      = 1'b0;
        in_vector_flat = 64'h0;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk_all_zero("idle");

        // Basic stream; vector input is scrambled after capture and must be ignored.
        in_vector_flat = VEC_A;
        in_done        = 1'b1;
        out_ready      = 1'b1;
        tick();
        in_vector_flat = 64'hAAAA_AAAA_AAAA_AAAA;
        stream("a", VEC_A, 0, 7);
        chk_finish("a", 3, 127);
        tick();
        chk("a_idle_busy", 32'(busy), 0);
        chk("a_idle_cvalid", 32'(class_valid), 0);
        chk("a_idle_cidx_hold", 32'(class_idx), ARGMAX_EN ? 3 : 0);
        chk("a_idle_ovr", 32'(overrun), 0);

        // Stall on idx 2 for three cycles with a dropped rise in the middle.
        in_done = 1'b0;
        tick();
        in_vector_flat = VEC_A;
        in_done        = 1'b1;
        tick();
        stream("b", VEC_A, 0, 1);
        chk("b_idx2", 32'(out_idx), 2);
        out_ready = 1'b0;
        tick();
        chk("b_hold1_data", 32'(out_data), 0);
        chk("b_hold1_idx", 32'(out_idx), 2);
        chk("b_hold1_valid", 32'(out_valid), 1);
        in_done = 1'b0;
        tick();
        chk("b_hold2_data", 32'(out_data), 0);
        chk("b_hold2_idx", 32'(out_idx), 2);
        in_vector_flat = 64'h7F7F_7F7F_7F7F_7F7F;
        in_done        = 1'b1;
        #1;
        chk("b_ovr_pulse", 32'(overrun), 1);
        tick();
        chk("b_ovr_clear", 32'(overrun), 0);
        chk("b_hold3_data", 32'(out_data), 0);
        chk("b_hold3_idx", 32'(out_idx), 2);
        out_ready = 1'b1;
        stream("b", VEC_A, 2, 7);
        chk_finish("b", 3, 127);
        tick();

        // All-negative vector; rise on the FINISH-to-IDLE edge is dropped.
        in_done = 1'b0;
        tick();
        in_vector_flat = VEC_N;
        in_done        = 1'b1;
        tick();
        in_done = 1'b0;
        stream("n", VEC_N, 0, 7);
        chk_finish("n", 7, 32'hFF);
        in_done = 1'b1;
        #1;
        chk("n_fin_ovr", 32'(overrun), 1);
        tick();
        chk("n_drop_busy", 32'(busy), 0);
        chk("n_drop_valid", 32'(out_valid), 0);
        chk("n_drop_ovr", 32'(overrun), 0);

        // Reset after four transfers, then in_done still high counts as a fresh rise.
        in_done = 1'b0;
        tick();
        in_vector_flat = VEC_A;
        in_done        = 1'b1;
        tick();
        stream("r", VEC_A, 0, 3);
        chk("r_pre_idx", 32'(out_idx), 4);
        reset = 1'b1;
        tick();
        chk_all_zero("r_mid");
        reset = 1'b0;
        tick();
        stream("r2", VEC_A, 0, 7);
        chk_finish("r2", 3, 127);
        tick();
        chk("r2_idle_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
